adder_seq_ctrl: RTL and testbench

Multi-cycle sequencer that computes WIDTH-bit add/subtract by reusing a single SLICE-bit ripple-carry slice over WIDTH/SLICE cycles, with a carry register between chunks. It sits between a requesting datapath and the shared adder hardware. Throughput is traded for area so that wide operands never need a full-width ripple chain. Requests and results use ready/valid handshakes.

---
 rtl/adder_pkg.sv | 17 +
 rtl/add_slice.sv | 24 ++
 rtl/adder_seq_ctrl.sv | 121 ++++++++++++
 tb/tb_adder_seq_ctrl.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared types and constants for the sliced adder sequencer
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int SLICE_DEFAULT = 4;

    // Chunk counter width, never below one bit so NCHUNK=1 still has a counter
    function automatic int kw_of(input int nchunk);
        return (nchunk <= 1) ? 1 : $clog2(nchunk);
    endfunction

endpackage

// File: rtl/add_slice.sv
// rtl/add_slice.sv - combinational ripple-carry slice of full adders
module add_slice #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co
);

    // Ripple the carry through W full adders
    always_comb begin : p_ripple
        logic c;
        c = ci;
        s = '0;
        for (int i = 0; i < W; i++) begin
            s[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        co = c;
    end

endmodule

// File: rtl/adder_seq_ctrl.sv
// rtl/adder_seq_ctrl.sv - multi-cycle add/subtract reusing one narrow adder slice
module adder_seq_ctrl
    import adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SLICE = SLICE_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   S,
    output logic             busy
);

    localparam int NCHUNK = WIDTH / SLICE;
    localparam int KW     = kw_of(NCHUNK);
    localparam logic [KW-1:0] KLAST = KW'(NCHUNK - 1);

    state_t            state, state_nxt;
    logic [WIDTH-1:0]  a_r, b_r;
    logic              carry;
    logic [KW-1:0]     k;
    logic [WIDTH:0]    s_r;

    logic [SLICE-1:0]  a_chunk, b_chunk, slice_s;
    logic              slice_co;
    logic              accept, last_chunk;

    assign accept     = (state == IDLE) && in_valid;
    assign last_chunk = (k == KLAST);

    // Select the current operand chunk with constant part-selects
    always_comb begin
        a_chunk = '0;
        b_chunk = '0;
        for (int i = 0; i < NCHUNK; i++) begin
            if (k == KW'(i)) begin
                a_chunk = a_r[i*SLICE +: SLICE];
                b_chunk = b_r[i*SLICE +: SLICE];
            end
        end
    end

    add_slice #(.W(SLICE)) u_slice (
        .a  (a_chunk),
        .b  (b_chunk),
        .ci (carry),
        .s  (slice_s),
        .co (slice_co)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)   state_nxt = RUN;
            RUN:     if (last_chunk) state_nxt = DONE;
            DONE:    if (out_ready)  state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    // Handshake and status outputs decoded from state
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE:    in_ready  = 1'b1;
            RUN:     busy      = 1'b1;
            DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            default: in_ready  = 1'b0;
        endcase
    end

    // Operand capture, carry chain between chunks and result accumulation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r   <= '0;
            b_r   <= '0;
            carry <= 1'b0;
            k     <= '0;
            s_r   <= '0;
        end else if (accept) begin
            a_r   <= a;
            b_r   <= sub ? ~b : b;
            carry <= sub ? 1'b1 : cin;
            k     <= '0;
        end else if (state == RUN) begin
            for (int i = 0; i < NCHUNK; i++) begin
                if (k == KW'(i)) s_r[i*SLICE +: SLICE] <= slice_s;
            end
            carry <= slice_co;
            if (last_chunk) begin
                s_r[WIDTH] <= slice_co;
                k          <= '0;
            end else begin
                k <= k + 1'b1;
            end
        end
    end

    assign S = s_r;

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// tb/tb_adder_seq_ctrl.sv - directed self-checking bench for adder_seq_ctrl
module tb_adder_seq_ctrl;

    localparam int WIDTH = 16;
    localparam int SLICE = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [WIDTH-1:0]  a = '0, b = '0;
    logic              cin = 1'b0, sub = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [WIDTH:0]    S;
    logic              busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    adder_seq_ctrl #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .S         (S),
        .busy      (busy)
    );

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             cin;
        logic             sub;
        logic [WIDTH:0]   s;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One transaction with out_ready held high; checks latency, result and release
    task automatic run_op(input string name, input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                          input logic vcin, input logic vsub, input logic [WIDTH:0] exp);
        int lat;
        check({name, " in_ready before"}, 32'(in_ready), 32'd1);
        a = va; b = vb; cin = vcin; sub = vsub;
        in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({name, " latency"}, 32'(lat), 32'd4);
        check({name, " S"}, 32'(S), 32'(exp));
        @(negedge clk);
        check({name, " out_valid one cycle"}, 32'(out_valid), 32'd0);
        check({name, " in_ready after"}, 32'(in_ready), 32'd1);
    endtask

    initial begin : main
        int lat;
        int cyc, last_acc, nacc, nres;
        logic [WIDTH:0] expq [$];

        vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 17'h10000};
        vecs[1] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 17'h05556};
        vecs[2] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 17'h0FFFE};
        vecs[3] = '{16'h0007, 16'h0005, 1'b0, 1'b1, 17'h10002};
        vecs[4] = '{16'h0007, 16'h0005, 1'b1, 1'b1, 17'h10002};
        vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 17'h1FFFF};
        vecs[6] = '{16'h0000, 16'h0000, 1'b0, 1'b0, 17'h00000};
        vecs[7] = '{16'h8000, 16'h8000, 1'b0, 1'b1, 17'h10000};

        #12;
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset S", 32'(S), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++)
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, vecs[i].s);

        // Backpressure: result must hold while out_ready stays low
        a = 16'h00AA; b = 16'h0011; cin = 1'b0; sub = 1'b0;
        in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("bp latency", 32'(lat), 32'd4);
        a = 16'h5555; b = 16'h3333; sub = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp S", 32'(S), 32'h000BB);
            check("bp out_valid", 32'(out_valid), 32'd1);
            check("bp in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        check("bp consumed", 32'(out_valid), 32'd0);
        check("bp in_ready after", 32'(in_ready), 32'd1);

        // Inputs changing during RUN must not disturb the result
        a = 16'h00FF; b = 16'h0001; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        a = 16'hFFFF; b = 16'hFFFF; sub = 1'b1; cin = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; a = 16'h1111;
        lat = 2;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("run-ignore latency", 32'(lat), 32'd4);
        check("run-ignore S", 32'(S), 32'h00100);
        @(negedge clk);
        check("run-ignore released", 32'(in_ready), 32'd1);

        // Asynchronous reset with two chunks done
        a = 16'h1234; b = 16'h1111; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("midrun busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async in_ready", 32'(in_ready), 32'd1);
        check("async out_valid", 32'(out_valid), 32'd0);
        check("async busy", 32'(busy), 32'd0);
        check("async S", 32'(S), 32'd0);
        @(negedge clk);
        @(negedge clk);
        check("held reset out_valid", 32'(out_valid), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        run_op("post-reset", 16'h0001, 16'h0001, 1'b0, 1'b0, 17'h00002);

        // Back-to-back with in_valid held high
        out_ready = 1'b1; in_valid = 1'b1; cin = 1'b0; sub = 1'b0;
        cyc = 0; last_acc = -1; nacc = 0; nres = 0;
        for (int t = 0; t < 30; t++) begin
            if (out_valid) begin
                check("b2b S", 32'(S), 32'(expq.pop_front()));
                nres++;
            end
            if (in_ready && in_valid) begin
                if (last_acc >= 0) check("b2b spacing", 32'(cyc - last_acc), 32'd6);
                last_acc = cyc;
                a = vecs[nacc].a; b = vecs[nacc].b;
                expq.push_back({1'b0, vecs[nacc].a} + {1'b0, vecs[nacc].b});
                nacc++;
                if (nacc == 3) begin
                    @(negedge clk);
                    cyc++;
                    in_valid = 1'b0;
                    continue;
                end
            end
            @(negedge clk);
            cyc++;
        end
        check("b2b results", 32'(nres), 32'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
